// File: rtl/ram_8x16_burst_master_pkg.sv
// Shared definitions for the 8x16 RAM burst master: default sizes, FSM states, op encodings.
package ram_8x16_burst_master_pkg;

  localparam int unsigned AW_DEF = 3;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

endpackage

// File: rtl/ram_8x16_burst_master_if.sv
// Host and memory-side signal bundle of the burst master.
interface ram_8x16_burst_master_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 16
);
  logic          start;
  logic          op;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  start, op, base, len, wr_data, wr_valid, rd_ready, mem_rdata,
    output wr_ready, rd_data, rd_valid, busy, done, checksum,
           mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    output start, op, base, len, wr_data, wr_valid, rd_ready, mem_rdata,
    input  wr_ready, rd_data, rd_valid, busy, done, checksum,
           mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_8x16_burst_master_burst_addr_gen.sv
// Burst address/count tracker: loads base/len, advances with modulo-2^AW wrap, flags last word.
module burst_addr_gen #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          advance,
  output logic [AW-1:0] cur_addr,
  output logic          last
);
  logic [AW-1:0] remaining;

  always_ff @(posedge clk) begin
    if (clr) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= base;
      remaining <= len;
    end else if (advance) begin
      cur_addr  <= cur_addr + AW'(1);
      remaining <= remaining - AW'(1);
    end
  end

  assign last = (remaining == '0);
endmodule

// File: rtl/ram_8x16_burst_master.sv
// Burst master for an 8x16 RAM: host write/read bursts with wrap-around addressing.
// Optional XOR checksum of transferred words enabled by macro BURST_CHECKSUM_EN.
module ram_8x16_burst_master
  import ram_8x16_burst_master_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                      clk,
  input  logic                      clr,
  ram_8x16_burst_master_if.master   bus
);
  state_e        state;
  logic          fetch_done;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic          done_q;
  logic [AW-1:0] cur_addr;
  logic          last;

  logic accept;
  logic write_beat;
  logic fetch;
  logic rd_hs;

  assign accept     = (state == ST_IDLE) && bus.start;
  assign write_beat = (state == ST_WRITE) && bus.wr_valid;
  // A word is fetched whenever the output register is free or being drained.
  assign fetch      = (state == ST_READ) && (!rd_valid_q || bus.rd_ready) && !fetch_done;
  assign rd_hs      = (state == ST_READ) && rd_valid_q && bus.rd_ready;

  burst_addr_gen #(.AW(AW)) u_addr_gen (
    .clk      (clk),
    .clr      (clr),
    .load     (accept),
    .base     (bus.base),
    .len      (bus.len),
    .advance  (write_beat || fetch),
    .cur_addr (cur_addr),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      fetch_done <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            fetch_done <= 1'b0;
            state      <= (bus.op == OP_WRITE) ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (bus.wr_valid && last) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (fetch) begin
            rd_data_q  <= bus.mem_rdata;
            rd_valid_q <= 1'b1;
            if (last) fetch_done <= 1'b1;
          end
          // Once everything is fetched, the word on the output is the final one.
          if (rd_hs && fetch_done) begin
            rd_valid_q <= 1'b0;
            state      <= ST_DONE;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_ready  = (state == ST_WRITE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_rw    = write_beat && !clr;
  assign bus.mem_addr  = cur_addr;
  assign bus.mem_wdata = bus.wr_data;

`ifdef BURST_CHECKSUM_EN
  logic [DW-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (clr || accept) csum_q <= '0;
    else if (write_beat) csum_q <= csum_q ^ bus.wr_data;
    else if (rd_hs)      csum_q <= csum_q ^ rd_data_q;
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_ram_8x16_burst_master.sv
// Self-checking bench for ram_8x16_burst_master with a behavioural 8-word memory reference.
module tb_ram_8x16_burst_master;
  import ram_8x16_burst_master_pkg::*;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  ram_8x16_burst_master_if #(.AW(AW), .DW(DW)) bus ();

  ram_8x16_burst_master #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Attached RAM: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.mem_rw) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  bit [DW-1:0] ref_mem [DEPTH];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_csum(input bit [DW-1:0] x);
`ifdef BURST_CHECKSUM_EN
    return 32'(x);
`else
    return 32'(x & 16'h0);
`endif
  endfunction

  task automatic check_mem();
    for (int a = 0; a < int'(DEPTH); a++) check("mem_content", 32'(mem[a]), 32'(ref_mem[a]));
  endtask

  task automatic do_write(input int b, input int l, input bit [DW-1:0] d[$], input bit rnd);
    bit [DW-1:0] cs = '0;
    bus.op = OP_WRITE; bus.base = AW'(b); bus.len = AW'(l);
    bus.start = 1'b1; bus.wr_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    check("wr_busy", 32'(bus.busy), 32'd1);
    check("wr_ready", 32'(bus.wr_ready), 32'd1);
    for (int i = 0; i <= l; i++) begin
      for (int s = 0; rnd && s < 3 && $urandom_range(3) == 0; s++) begin
        bus.wr_valid = 1'b0;
        bus.start = 1'($urandom_range(1)); bus.op = 1'($urandom_range(1));
        bus.base = AW'($urandom); bus.len = AW'($urandom);
        #1;
        check("wr_stall_rw", 32'(bus.mem_rw), 32'd0);
        tick();
      end
      bus.wr_valid = 1'b1; bus.wr_data = d[i];
      bus.start = rnd ? 1'($urandom_range(1)) : 1'b0;
      #1;
      check("wr_rw", 32'(bus.mem_rw), 32'd1);
      check("wr_addr", 32'(bus.mem_addr), 32'((b + i) % int'(DEPTH)));
      check("wr_wdata", 32'(bus.mem_wdata), 32'(d[i]));
      tick();
      cs ^= d[i];
    end
    bus.wr_valid = 1'b0; bus.start = 1'b0;
    #1;
    check("wr_done", 32'(bus.done), 32'd1);
    check("wr_ready_done", 32'(bus.wr_ready), 32'd0);
    check("wr_rw_done", 32'(bus.mem_rw), 32'd0);
    check("wr_csum_done", 32'(bus.checksum), exp_csum(cs));
    tick();
    check("wr_done_pulse", 32'(bus.done), 32'd0);
    check("wr_idle", 32'(bus.busy), 32'd0);
    check("wr_csum_idle", 32'(bus.checksum), exp_csum(cs));
    for (int i = 0; i <= l; i++) ref_mem[(b + i) % int'(DEPTH)] = d[i];
    check_mem();
  endtask

  task automatic do_read(input int b, input int l, input bit all_ready, input int hold_in);
    bit [DW-1:0] cs = '0;
    int k = 0, cyc = 0, first = -1, hold = hold_in;
    bit rdy;
    bus.op = OP_READ; bus.base = AW'(b); bus.len = AW'(l);
    bus.start = 1'b1; bus.rd_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    while (k <= l && cyc < 100) begin
      if (bus.rd_valid && first < 0) begin
        first = cyc;
        check("rd_first_latency", 32'(first), 32'd1);
      end
      rdy = (hold > 0) ? 1'b0 : (all_ready ? 1'b1 : 1'($urandom_range(1)));
      bus.rd_ready = rdy;
      bus.start = 1'($urandom_range(1)); bus.base = AW'($urandom); bus.op = 1'($urandom_range(1));
      #1;
      check("rd_rw", 32'(bus.mem_rw), 32'd0);
      if (bus.rd_valid) begin
        check("rd_data", 32'(bus.rd_data), 32'(ref_mem[(b + k) % int'(DEPTH)]));
        if (!rdy) begin
          check("rd_hold_addr", 32'(bus.mem_addr), 32'((b + k + 1) % int'(DEPTH)));
          if (hold > 0) hold--;
        end else begin
          cs ^= bus.rd_data;
          k++;
        end
      end
      tick();
      cyc++;
    end
    if (k <= l) check("rd_timeout_words", 32'(k), 32'(l + 1));
    bus.rd_ready = 1'b0; bus.start = 1'b0;
    #1;
    check("rd_done", 32'(bus.done), 32'd1);
    check("rd_valid_cleared", 32'(bus.rd_valid), 32'd0);
    check("rd_csum_done", 32'(bus.checksum), exp_csum(cs));
    if (all_ready && hold_in == 0) check("rd_throughput", 32'(cyc), 32'(l + 2));
    tick();
    check("rd_done_pulse", 32'(bus.done), 32'd0);
    check("rd_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit [DW-1:0] d[$];
    clr = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.base = '0; bus.len = '0;
    bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_checksum", 32'(bus.checksum), 32'd0);
    clr = 1'b0;
    tick();

    // Full write 0x1000..0x1007, then wrapped read and a back-pressured read.
    d = {};
    for (int i = 0; i < 8; i++) d.push_back(16'(32'h1000 + i));
    do_write(0, 7, d, 1'b0);
    do_read(6, 3, 1'b1, 0);
    do_read(6, 1, 1'b1, 3);

    // Checksum of a two-word write.
    d = {16'h00FF, 16'h0F0F};
    do_write(0, 1, d, 1'b0);
`ifdef BURST_CHECKSUM_EN
    check("csum_const", 32'(bus.checksum), 32'h0FF0);
`else
    check("csum_const", 32'(bus.checksum), 32'h0);
`endif

    // Abort an 8-word write with clr on beat 3.
    bus.op = OP_WRITE; bus.base = '0; bus.len = 3'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 16'(32'h2000 + i);
      if (i == 2) clr = 1'b1;
      #1;
      check("abort_rw", 32'(bus.mem_rw), (i == 2) ? 32'd0 : 32'd1);
      tick();
    end
    clr = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_checksum", 32'(bus.checksum), 32'd0);
    bus.wr_data = 16'hDEAD;
    #1;
    check("abort_idle_rw", 32'(bus.mem_rw), 32'd0);
    tick();
    bus.wr_valid = 1'b0;
    check("abort_still_idle", 32'(bus.busy), 32'd0);
    ref_mem[0] = 16'h2000; ref_mem[1] = 16'h2001;
    check_mem();

    // Random bursts with stalls, back-pressure and ignored starts.
    for (int n = 0; n < 20; n++) begin
      int b = int'($urandom_range(7));
      int l = int'($urandom_range(7));
      if ($urandom_range(1) == 1) begin
        d = {};
        for (int i = 0; i <= l; i++) d.push_back(16'($urandom));
        do_write(b, l, d, 1'b1);
      end else begin
        do_read(b, l, 1'b0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_8x16_burst_master.md
RAM_8X16_BURST_MASTER -- requirements
Module: ram_8x16_burst_master

Interface
REQ-001 Parameter AW, default 3, memory address width (8 words).
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  burst request, sampled only when busy=0.
REQ-006 op  input  1  burst type: 1=write burst, 0=read burst.
REQ-007 base  input  AW  first word address of burst.
REQ-008 len  input  AW  burst length minus one (0..7 gives 1..8 words).
REQ-009 wr_data  input  DW  host write word.
REQ-010 wr_valid  input  1  wr_data valid.
REQ-011 wr_ready  output  1  master accepts wr_data this cycle.
REQ-012 rd_data  output  DW  registered read word to host.
REQ-013 rd_valid  output  1  rd_data valid.
REQ-014 rd_ready  input  1  host consumes rd_data.
REQ-015 busy  output  1  burst in progress (state not IDLE).
REQ-016 done  output  1  one-cycle pulse at burst completion.
REQ-017 checksum  output  DW  XOR of burst words (see Configuration).
REQ-018 mem_rw  output  1  to memory rw: 1=write, 0=read.
REQ-019 mem_addr  output  AW  to memory addr.
REQ-020 mem_wdata  output  DW  to memory data_in.
REQ-021 mem_rdata  input  DW  from memory data_out; valid combinationally in the same cycle mem_rw=0 and mem_addr are presented.

Function
REQ-022 FSM states SHALL be IDLE, WRITE, READ, DONE; busy=1 in WRITE, READ, DONE.
REQ-023 IDLE: start=1 SHALL latch op, cur_addr=base, remaining=len, and go to WRITE (op=1) or READ (op=0); start while busy=1 SHALL be ignored.
REQ-024 WRITE: wr_ready=1; mem_rw=wr_valid (combinational); mem_addr=cur_addr; mem_wdata=wr_data; each wr_valid beat SHALL write the word at that edge, advance cur_addr, decrement remaining.
REQ-025 WRITE: beat with remaining=0 SHALL go to DONE; wr_valid=0 cycles SHALL stall without memory write.
REQ-026 READ: mem_rw=0, mem_addr=cur_addr; when rd_valid=0 or rd_ready=1 and words remain, SHALL load rd_data<=mem_rdata, set rd_valid=1, advance cur_addr.
REQ-027 READ: rd_valid=1 with rd_ready=0 SHALL hold rd_data, rd_valid, and cur_addr stable.
REQ-028 READ: first rd_valid SHALL assert 2 cycles after the start edge; full throughput 1 word/cycle with rd_ready=1.
REQ-029 READ: handshake (rd_valid & rd_ready) of the last word SHALL clear rd_valid and go to DONE.
REQ-030 cur_addr SHALL wrap 7->0 modulo 2^AW (base=6, len=3 touches 6,7,0,1).
REQ-031 DONE: done=1 for exactly one cycle, then IDLE; wr_ready=0 and mem_rw=0 outside WRITE.
REQ-032 mem_rw SHALL never be 1 outside WRITE or in reset.

Reset
REQ-033 clr=1 SHALL force IDLE, busy=0, done=0, rd_valid=0, rd_data=0, wr_ready=0, mem_rw=0, mem_addr=0, checksum=0.
REQ-034 clr mid-burst SHALL abort it with no further memory write and no done pulse; memory contents untouched by the master.

Configuration
REQ-035 Macro BURST_CHECKSUM_EN defined: checksum cleared on start acceptance, XOR-accumulates each transferred word (write beat or read handshake), stable from done until next start.
REQ-036 Macro BURST_CHECKSUM_EN undefined: checksum SHALL be constant 0 and no accumulator logic exists; all other behaviour identical.

Structure
REQ-037 Shared package SHALL hold AW/DW defaults, FSM state encoding, and op encodings OP_WRITE=1, OP_READ=0.
REQ-038 One sub-module burst_addr_gen SHALL hold cur_addr/remaining (load, advance, wrap, last flag).

Verification
REQ-039 Write base=0, len=7, wr_data 0x1000..0x1007, wr_valid=1 -> 8 consecutive mem_rw=1 cycles, addr 0..7, done 1 cycle after last beat.
REQ-040 Read base=6, len=3 after REQ-039, rd_ready=1 -> rd_data 0x1006,0x1007,0x1000,0x1001, first rd_valid 2 cycles after start.
REQ-041 Read len=1, rd_ready=0 for 3 cycles after first rd_valid -> rd_data 0x1006 held, mem_addr=7 stable, no word lost.
REQ-042 start pulsed while busy -> ignored; in-progress burst count and addresses unchanged.
REQ-043 clr asserted during write beat 3 of 8 -> beats 4..8 never written, busy=0 and done=0 next cycle.
REQ-044 BURST_CHECKSUM_EN: write 0x00FF,0x0F0F -> checksum=0x0FF0 at done; undefined -> checksum=0.
